// File: rtl/gato_pkg.sv
// Shared definitions for the tic-tac-toe (gato) game sequencer: cell codes,
// FSM state encoding and board-evaluation helpers.
package gato_pkg;

   localparam logic [1:0] VACIO   = 2'b00;
   localparam logic [1:0] EQUIS   = 2'b11;
   localparam logic [1:0] CIRCULO = 2'b01;

   typedef enum logic [2:0] {
      ESPERA   = 3'd0,
      JUEGA_P1 = 3'd1,
      JUEGA_P2 = 3'd2,
      EVAL1    = 3'd3,
      EVAL2    = 3'd4,
      FIN      = 3'd5
   } estado_t;

   // Cell n (1..9) lives at tablero[2n-1:2n-2].
   function automatic logic [1:0] celda(input logic [17:0] tab, input logic [3:0] n);
      logic [4:0] idx;
      idx = {n, 1'b0} - 5'd2;
      return tab[idx +: 2];
   endfunction

   // True when any row, column or diagonal holds three cells equal to codigo.
   function automatic logic linea_completa(input logic [17:0] tab, input logic [1:0] codigo);
      logic [8:0] m;
      for (int i = 0; i < 9; i++) m[i] = (tab[2*i +: 2] == codigo);
      return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
             (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
             (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
   endfunction

   // True when no cell is empty.
   function automatic logic tablero_lleno(input logic [17:0] tab);
      logic lleno;
      lleno = 1'b1;
      for (int i = 0; i < 9; i++) if (tab[2*i +: 2] == VACIO) lleno = 1'b0;
      return lleno;
   endfunction

endpackage

// File: rtl/controlador_partida_gato_if.sv
// Button-side / drawing-side bundle of the game sequencer.
// Buttons are plain levels already synchronised to clk; there is no
// valid/ready handshake: a command is the rising edge of a level, and the
// controller always accepts it in the cycle it is detected. jugada_ok and
// jugada_mala are single-cycle strobes; everything else is a held level.
interface controlador_partida_gato_if;
   import gato_pkg::*;

   logic        boton_arriba;
   logic        boton_abajo;
   logic        boton_izq;
   logic        boton_der;
   logic        boton_elige;
   logic        boton_inicio;
   logic [3:0]  cuadro;
   logic [17:0] tablero;
   logic        turno_p1;
   logic        turno_p2;
   logic        jugada_ok;
   logic        jugada_mala;
   logic [1:0]  ganador;
   logic        empate;
   estado_t     estado;

   modport master (
      output boton_arriba, boton_abajo, boton_izq, boton_der, boton_elige, boton_inicio,
      input  cuadro, tablero, turno_p1, turno_p2, jugada_ok, jugada_mala, ganador, empate, estado
   );

   modport slave (
      input  boton_arriba, boton_abajo, boton_izq, boton_der, boton_elige, boton_inicio,
      output cuadro, tablero, turno_p1, turno_p2, jugada_ok, jugada_mala, ganador, empate, estado
   );

endinterface

// File: rtl/detector_flanco.sv
// Registered rising-edge detector: one single-cycle pulse per press.
// Reset loads the current level so a button held through reset gives no pulse.
module detector_flanco (
   input  logic clk,
   input  logic rst_n,
   input  logic nivel,
   output logic pulso
);

   logic previo;

   // Remember last level and flag a 0->1 transition.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         previo <= nivel;
         pulso  <= 1'b0;
      end else begin
         previo <= nivel;
         pulso  <= nivel & ~previo;
      end
   end

endmodule

// File: rtl/controlador_partida_gato.sv
// Tic-tac-toe game sequencer: button edges -> cursor, board, turn and result.
module controlador_partida_gato
   import gato_pkg::*;
#(
   parameter int CURSOR_INICIAL = 5,
   parameter int TIMEOUT_TURNO  = 0,
   parameter int ANCHO_TIMEOUT  = 28
) (
   input logic clk,
   input logic rst_n,
   controlador_partida_gato_if.slave bus
);

   localparam logic [3:0] CURSOR_RST = 4'(CURSOR_INICIAL);
   localparam logic [ANCHO_TIMEOUT-1:0] LIMITE =
      (TIMEOUT_TURNO > 0) ? ANCHO_TIMEOUT'(TIMEOUT_TURNO - 1) : '0;

   logic p_arriba, p_abajo, p_izq, p_der, p_elige, p_inicio;

   detector_flanco u_det_arriba (.clk(clk), .rst_n(rst_n), .nivel(bus.boton_arriba), .pulso(p_arriba));
   detector_flanco u_det_abajo  (.clk(clk), .rst_n(rst_n), .nivel(bus.boton_abajo),  .pulso(p_abajo));
   detector_flanco u_det_izq    (.clk(clk), .rst_n(rst_n), .nivel(bus.boton_izq),    .pulso(p_izq));
   detector_flanco u_det_der    (.clk(clk), .rst_n(rst_n), .nivel(bus.boton_der),    .pulso(p_der));
   detector_flanco u_det_elige  (.clk(clk), .rst_n(rst_n), .nivel(bus.boton_elige),  .pulso(p_elige));
   detector_flanco u_det_inicio (.clk(clk), .rst_n(rst_n), .nivel(bus.boton_inicio), .pulso(p_inicio));

   estado_t                estado, estado_sig;
   logic [3:0]             cuadro, cuadro_sig;
   logic [17:0]            tablero, tablero_sig;
   logic                   ok, ok_sig, mala, mala_sig;
   logic [1:0]             ganador, ganador_sig;
   logic                   empate, empate_sig;
   logic [ANCHO_TIMEOUT-1:0] timer, timer_sig;

   logic       movio, elige_actua;
   logic [1:0] codigo;
   logic [4:0] idx;

   // State and datapath registers; reset aborts any game in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado  <= ESPERA;
         cuadro  <= CURSOR_RST;
         tablero <= '0;
         ok      <= 1'b0;
         mala    <= 1'b0;
         ganador <= VACIO;
         empate  <= 1'b0;
         timer   <= '0;
      end else begin
         estado  <= estado_sig;
         cuadro  <= cuadro_sig;
         tablero <= tablero_sig;
         ok      <= ok_sig;
         mala    <= mala_sig;
         ganador <= ganador_sig;
         empate  <= empate_sig;
         timer   <= timer_sig;
      end
   end

   // Next state: one command per cycle, inicio > abajo > arriba > izq > der > elige.
   always_comb begin
      estado_sig  = estado;
      cuadro_sig  = cuadro;
      tablero_sig = tablero;
      ok_sig      = 1'b0;
      mala_sig    = 1'b0;
      ganador_sig = ganador;
      empate_sig  = empate;
      timer_sig   = timer;
      movio       = 1'b0;
      elige_actua = 1'b0;
      codigo      = (estado == JUEGA_P1) ? EQUIS : CIRCULO;
      idx         = {cuadro, 1'b0} - 5'd2;

      if (p_inicio) begin
         tablero_sig = '0;
         ganador_sig = VACIO;
         empate_sig  = 1'b0;
         cuadro_sig  = CURSOR_RST;
         timer_sig   = '0;
         estado_sig  = JUEGA_P1;
      end else begin
         case (estado)
            JUEGA_P1, JUEGA_P2: begin
               if (TIMEOUT_TURNO > 0) timer_sig = timer + 1'b1;
               if (p_abajo) begin
                  if (cuadro > 4'd3) begin cuadro_sig = cuadro - 4'd3; movio = 1'b1; end
               end else if (p_arriba) begin
                  if (cuadro < 4'd7) begin cuadro_sig = cuadro + 4'd3; movio = 1'b1; end
               end else if (p_izq) begin
                  if (cuadro != 4'd1 && cuadro != 4'd4 && cuadro != 4'd7) begin
                     cuadro_sig = cuadro - 4'd1; movio = 1'b1;
                  end
               end else if (p_der) begin
                  if (cuadro != 4'd3 && cuadro != 4'd6 && cuadro != 4'd9) begin
                     cuadro_sig = cuadro + 4'd1; movio = 1'b1;
                  end
               end else if (p_elige) begin
                  elige_actua = 1'b1;
                  if (celda(tablero, cuadro) == VACIO) begin
                     tablero_sig[idx +: 2] = codigo;
                     ok_sig     = 1'b1;
                     estado_sig = (estado == JUEGA_P1) ? EVAL1 : EVAL2;
                  end else begin
                     mala_sig = 1'b1;
                  end
               end
               if (movio) timer_sig = '0;
               // Expiry loses to a processed elige or a real cursor move.
               if (TIMEOUT_TURNO > 0 && !movio && !elige_actua && timer >= LIMITE) begin
                  timer_sig  = '0;
                  estado_sig = (estado == JUEGA_P1) ? JUEGA_P2 : JUEGA_P1;
               end
            end
            EVAL1, EVAL2: begin
               codigo    = (estado == EVAL1) ? EQUIS : CIRCULO;
               timer_sig = '0;
               if (linea_completa(tablero, codigo)) begin
                  ganador_sig = codigo;
                  estado_sig  = FIN;
               end else if (tablero_lleno(tablero)) begin
                  empate_sig = 1'b1;
                  estado_sig = FIN;
               end else begin
                  estado_sig = (estado == EVAL1) ? JUEGA_P2 : JUEGA_P1;
               end
            end
            default: ;
         endcase
      end
   end

   // Drive the bundle; turn flags are decoded from state so they can never overlap.
   assign bus.cuadro      = cuadro;
   assign bus.tablero     = tablero;
   assign bus.turno_p1    = (estado == JUEGA_P1);
   assign bus.turno_p2    = (estado == JUEGA_P2);
   assign bus.jugada_ok   = ok;
   assign bus.jugada_mala = mala;
   assign bus.ganador     = ganador;
   assign bus.empate      = empate;
   assign bus.estado      = estado;

endmodule

// File: tb/tb_controlador_partida_gato.sv
// Bench for the game sequencer: default instance for gameplay, second
// instance with a 16-cycle turn timeout.
module tb_controlador_partida_gato;
   import gato_pkg::*;

   localparam int B_ARRIBA = 0, B_ABAJO = 1, B_IZQ = 2, B_DER = 3, B_ELIGE = 4, B_INICIO = 5;
   localparam int W = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   controlador_partida_gato_if bus0 ();
   controlador_partida_gato_if bus1 ();

   controlador_partida_gato dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   controlador_partida_gato #(.TIMEOUT_TURNO(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   // Clock.
   always #5 clk = ~clk;

   int errores = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];
   logic [17:0]  tab_m;
   logic [3:0]   cur_m;

   task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      if (obs !== esp) begin
         errores++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
      end
   endtask

   task automatic poner(input int b, input logic v);
      case (b)
         B_ARRIBA: bus0.boton_arriba = v;
         B_ABAJO:  bus0.boton_abajo  = v;
         B_IZQ:    bus0.boton_izq    = v;
         B_DER:    bus0.boton_der    = v;
         B_ELIGE:  bus0.boton_elige  = v;
         default:  bus0.boton_inicio = v;
      endcase
   endtask

   // Press and release one button; returns once the move and evaluation are visible.
   task automatic pulsar(input int b);
      @(negedge clk); poner(b, 1'b1);
      @(negedge clk); poner(b, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   // Walk the cursor to cell c with the arrow buttons, checking each step.
   task automatic ir_a(input logic [3:0] c);
      int fc, cc, fm, cm;
      for (int k = 0; k < 6 && cur_m != c; k++) begin
         fc = (int'(c) - 1) / 3; cc = (int'(c) - 1) % 3;
         fm = (int'(cur_m) - 1) / 3; cm = (int'(cur_m) - 1) % 3;
         if (fc > fm)      begin pulsar(B_ARRIBA); cur_m = cur_m + 4'd3; end
         else if (fc < fm) begin pulsar(B_ABAJO);  cur_m = cur_m - 4'd3; end
         else if (cc > cm) begin pulsar(B_DER);    cur_m = cur_m + 4'd1; end
         else              begin pulsar(B_IZQ);    cur_m = cur_m - 4'd1; end
         chequear("cursor_paso", bus0.cuadro, cur_m);
      end
   endtask

   // Place a mark for the player with code codigo at cell c.
   task automatic jugar(input logic [3:0] c, input logic [1:0] codigo);
      int i;
      ir_a(c);
      i = 2 * int'(c) - 2;
      if (tab_m[i +: 2] == 2'b00) begin
         tab_m[i +: 2] = codigo;
         exp_q.push_back({1'b1, 1'b0, tab_m});
      end else begin
         exp_q.push_back({1'b0, 1'b1, tab_m});
      end
      pulsar(B_ELIGE);
   endtask

   // Scoreboard: every ok/mala strobe must match the next expected move result.
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (rst_n && (bus0.jugada_ok || bus0.jugada_mala)) begin
         if (exp_q.size() == 0) begin
            chequear("pulso_inesperado", {bus0.jugada_ok, bus0.jugada_mala, bus0.tablero}, '0);
         end else begin
            e = exp_q.pop_front();
            chequear("jugada", {bus0.jugada_ok, bus0.jugada_mala, bus0.tablero}, e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int btn_t[12] = '{B_DER, B_ARRIBA, B_ARRIBA, B_DER, B_IZQ, B_IZQ, B_ABAJO, B_ABAJO, B_ABAJO, B_IZQ, B_ARRIBA, B_IZQ};
   int cur_t[12] = '{6, 9, 9, 9, 8, 7, 4, 1, 1, 1, 4, 4};
   int cuenta;

   initial begin
      bus0.boton_arriba = 0; bus0.boton_abajo = 0; bus0.boton_izq = 0;
      bus0.boton_der = 1; bus0.boton_elige = 0; bus0.boton_inicio = 0;
      bus1.boton_arriba = 0; bus1.boton_abajo = 0; bus1.boton_izq = 0;
      bus1.boton_der = 0; bus1.boton_elige = 0; bus1.boton_inicio = 0;
      tab_m = '0; cur_m = 4'd5;

      // 1: reset with der held
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chequear("rst_cuadro", bus0.cuadro, 5);
      chequear("rst_tablero", bus0.tablero, 0);
      chequear("rst_turnos", {bus0.turno_p1, bus0.turno_p2}, 0);
      chequear("rst_resultado", {bus0.ganador, bus0.empate, bus0.jugada_ok, bus0.jugada_mala}, 0);
      chequear("rst_estado", bus0.estado, ESPERA);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      pulsar(B_INICIO);
      chequear("inicio_turno_p1", bus0.turno_p1, 1);
      chequear("der_sostenido", bus0.cuadro, 5);
      bus0.boton_der = 0;
      repeat (2) @(negedge clk);
      pulsar(B_DER);
      chequear("der_una_vez", bus0.cuadro, 6);

      // 2: first move latency, then rejected move on the same cell
      pulsar(B_INICIO);
      cur_m = 4'd5; tab_m = '0;
      chequear("reinicio_cuadro", bus0.cuadro, 5);
      tab_m[9:8] = EQUIS;
      exp_q.push_back({1'b1, 1'b0, tab_m});
      @(negedge clk); bus0.boton_elige = 1;
      @(negedge clk); bus0.boton_elige = 0;
      @(negedge clk);
      chequear("lat_ok_n1", bus0.jugada_ok, 1);
      chequear("lat_turnos_eval", {bus0.turno_p1, bus0.turno_p2}, 0);
      @(negedge clk);
      chequear("lat_ok_un_ciclo", bus0.jugada_ok, 0);
      chequear("lat_turno_p2", {bus0.turno_p1, bus0.turno_p2}, 2'b01);
      repeat (2) @(negedge clk);
      jugar(4'd5, CIRCULO);
      chequear("mala_turno_p2", bus0.turno_p2, 1);
      chequear("mala_tablero", bus0.tablero, tab_m);

      // 3: cursor clamping at the board edges
      for (int i = 0; i < 12; i++) begin
         pulsar(btn_t[i]);
         chequear("limite_cursor", bus0.cuadro, cur_t[i]);
      end

      // 4: X wins on cells 1,2,3
      pulsar(B_INICIO);
      cur_m = 4'd5; tab_m = '0;
      jugar(4'd1, EQUIS);  jugar(4'd4, CIRCULO);
      jugar(4'd2, EQUIS);  jugar(4'd5, CIRCULO);
      chequear("sin_ganador_aun", bus0.ganador, 0);
      jugar(4'd3, EQUIS);
      chequear("gana_x", bus0.ganador, 2'b11);
      chequear("gana_turnos", {bus0.turno_p1, bus0.turno_p2}, 0);
      pulsar(B_ELIGE);
      pulsar(B_IZQ);
      chequear("fin_cuadro", bus0.cuadro, 3);
      chequear("fin_tablero", bus0.tablero, tab_m);
      chequear("fin_ganador", bus0.ganador, 2'b11);
      pulsar(B_INICIO);
      cur_m = 4'd5; tab_m = '0;
      chequear("post_fin_tablero", bus0.tablero, 0);
      chequear("post_fin_estado", {bus0.turno_p1, bus0.cuadro, bus0.ganador}, {1'b1, 4'd5, 2'b00});

      // 5: draw, then inicio and der in the same cycle
      jugar(4'd5, EQUIS); jugar(4'd1, CIRCULO); jugar(4'd9, EQUIS);
      jugar(4'd7, CIRCULO); jugar(4'd4, EQUIS); jugar(4'd6, CIRCULO);
      jugar(4'd3, EQUIS); jugar(4'd2, CIRCULO);
      chequear("sin_empate_aun", bus0.empate, 0);
      jugar(4'd8, EQUIS);
      chequear("empate", {bus0.empate, bus0.ganador}, {1'b1, 2'b00});
      @(negedge clk); bus0.boton_inicio = 1; bus0.boton_der = 1;
      @(negedge clk); bus0.boton_inicio = 0; bus0.boton_der = 0;
      repeat (3) @(negedge clk);
      cur_m = 4'd5; tab_m = '0;
      chequear("simult_cuadro", bus0.cuadro, 5);
      chequear("simult_result", {bus0.empate, bus0.tablero, bus0.turno_p1}, {1'b0, 18'd0, 1'b1});

      // 6: turn timeout on the second instance
      @(negedge clk); bus1.boton_inicio = 1;
      @(negedge clk); bus1.boton_inicio = 0;
      cuenta = 0;
      while (!bus1.turno_p1 && cuenta < 20) begin @(negedge clk); cuenta++; end
      chequear("to_inicio", bus1.turno_p1, 1);
      cuenta = 0;
      while (!bus1.turno_p2 && cuenta < 40) begin @(negedge clk); cuenta++; end
      chequear("to_ciclos", cuenta, 16);
      chequear("to_tablero", bus1.tablero, 0);
      @(negedge clk); bus1.boton_inicio = 1;
      @(negedge clk); bus1.boton_inicio = 0;
      cuenta = 0;
      while (!bus1.turno_p1 && cuenta < 20) begin @(negedge clk); cuenta++; end
      chequear("to_reinicio", bus1.turno_p1, 1);
      repeat (14) @(negedge clk);
      bus1.boton_elige = 1;
      @(negedge clk); bus1.boton_elige = 0;
      @(negedge clk);
      chequear("to_elige_marca", bus1.tablero, 18'h00300);
      chequear("to_elige_ok", {bus1.jugada_ok, bus1.turno_p2}, 2'b10);
      @(negedge clk);
      chequear("to_elige_turno", {bus1.turno_p1, bus1.turno_p2}, 2'b01);

      repeat (4) @(negedge clk);
      chequear("cola_vacia", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errores, checks);
      $finish;
   end

endmodule
